fifo_wr_arbiter: RTL and testbench

- Round-robin burst arbiter that shares the single FIFO write port (wr_enb/wr_data) between two producers.
- Grants one producer at a time for a requested burst length and forwards its data beats into the FIFO.
- Stalls on fifo_full, refuses new bursts on fifo_almost_full, and aborts a burst stalled too long.
- Sits between the producer blocks and the FIFO write side; the FIFO monitor observes its wr_enb/wr_data.

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two producers.
// A granted producer streams a burst of beats; fifo_full stalls, long stalls abort.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 4,
    parameter int STALL_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [LEN_W-1:0]  len0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    output logic              ack0,
    input  logic              req1,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic              ack1,
    input  logic              fifo_full,
    input  logic              fifo_almost_full,
    output logic              wr_enb,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              stall_abort
);
    localparam int SC_W = $clog2(STALL_MAX + 1);
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_MAX - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state;
    logic             owner;
    logic             last;
    logic [LEN_W-1:0] remaining;
    logic [SC_W-1:0]  stall_cnt;

    logic             pick;
    logic             pick_valid;
    logic [LEN_W-1:0] pick_len;

    // Beat handshake: while gntX is high the producer holds dataX stable;
    // ackX high in a cycle means that beat is written and the next may follow.
    always_comb begin
        wr_enb  = (state == S_BURST) && !fifo_full;
        wr_data = '0;
        if (state == S_BURST) begin
            wr_data = owner ? data1 : data0;
        end
        ack0 = wr_enb && !owner;
        ack1 = wr_enb && owner;
    end

    // New bursts only start with headroom in the FIFO; ties go to the producer not served last.
    always_comb begin
        pick       = 1'b0;
        pick_valid = 1'b0;
        if (!fifo_full && !fifo_almost_full) begin
            if (req0 && req1) begin
                pick_valid = 1'b1;
                pick       = ~last;
            end else if (req0) begin
                pick_valid = 1'b1;
                pick       = 1'b0;
            end else if (req1) begin
                pick_valid = 1'b1;
                pick       = 1'b1;
            end
        end
        pick_len = pick ? len1 : len0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            busy        <= 1'b0;
            stall_abort <= 1'b0;
            remaining   <= '0;
            stall_cnt   <= '0;
        end else begin
            stall_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state     <= S_BURST;
                        owner     <= pick;
                        gnt0      <= !pick;
                        gnt1      <= pick;
                        busy      <= 1'b1;
                        remaining <= (pick_len == '0) ? LEN_W'(1) : pick_len;
                        stall_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (!fifo_full) begin
                        remaining <= remaining - 1'b1;
                        stall_cnt <= '0;
                        if (remaining == LEN_W'(1)) begin
                            state <= S_IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            busy  <= 1'b0;
                            last  <= owner;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        // Give up on the burst; the producer sees gnt drop without a final ack.
                        state       <= S_IDLE;
                        gnt0        <= 1'b0;
                        gnt1        <= 1'b0;
                        busy        <= 1'b0;
                        last        <= owner;
                        stall_abort <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a burst-level model of the arbiter.
module tb_fifo_wr_arbiter;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 4;
    localparam int STALL_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1;
    logic [LEN_W-1:0]  len0, len1;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, ack0, ack1;
    logic              fifo_full, fifo_almost_full;
    logic              wr_enb;
    logic [DATA_W-1:0] wr_data;
    logic              busy, stall_abort;

    int checks = 0;
    int errors = 0;

    // Model: which producer owns the port (-1 none), beats left, consecutive full cycles.
    int  m_owner = -1;
    int  m_left  = 0;
    int  m_run   = 0;
    int  m_last  = 1;
    bit  m_abort = 1'b0;
    bit  m_valid = 1'b0;

    logic              e_wr;
    logic [DATA_W-1:0] e_data;

    logic [DATA_W-1:0] src0[$];
    logic [DATA_W-1:0] src1[$];
    logic [DATA_W-1:0] wlog_d[$];
    int                wlog_p[$];
    logic [DATA_W-1:0] exp_q[$];
    int                exp_p[$];
    int                abort_cnt = 0;

    fifo_wr_arbiter #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .len0(len0),
        .data0(data0),
        .gnt0(gnt0),
        .ack0(ack0),
        .req1(req1),
        .len1(len1),
        .data1(data1),
        .gnt1(gnt1),
        .ack1(ack1),
        .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .wr_enb(wr_enb),
        .wr_data(wr_data),
        .busy(busy),
        .stall_abort(stall_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Compare process: outputs settle after the falling edge, then the model steps.
    always @(negedge clk) begin
        #2;
        if (m_valid) begin
            e_wr   = (m_owner >= 0) && !fifo_full;
            e_data = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : '0;
            chk("gnt0", gnt0, (m_owner == 0));
            chk("gnt1", gnt1, (m_owner == 1));
            chk("busy", busy, (m_owner >= 0));
            chk("stall_abort", stall_abort, m_abort);
            chk("wr_enb", wr_enb, e_wr);
            chk("wr_data", wr_data, e_data);
            chk("ack0", ack0, e_wr && (m_owner == 0));
            chk("ack1", ack1, e_wr && (m_owner == 1));
            if (wr_enb === 1'b1) begin
                wlog_d.push_back(wr_data);
                wlog_p.push_back((ack1 === 1'b1) ? 1 : 0);
            end
            if (ack0 === 1'b1 && src0.size() > 0) void'(src0.pop_front());
            if (ack1 === 1'b1 && src1.size() > 0) void'(src1.pop_front());
            if (stall_abort === 1'b1) abort_cnt++;
        end
        if (rst === 1'b1) begin
            m_owner = -1;
            m_left  = 0;
            m_run   = 0;
            m_last  = 1;
            m_abort = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_abort = 1'b0;
            if (m_owner < 0) begin
                if (!fifo_full && !fifo_almost_full && (req0 || req1)) begin
                    if (req0 && req1) m_owner = 1 - m_last;
                    else              m_owner = req1 ? 1 : 0;
                    m_left = (m_owner == 0) ? int'(len0) : int'(len1);
                    if (m_left == 0) m_left = 1;
                    m_run = 0;
                end
            end else if (!fifo_full) begin
                m_left--;
                m_run = 0;
                if (m_left == 0) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_run++;
                if (m_run == STALL_MAX) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_abort = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        data0 = (src0.size() > 0) ? src0[0] : DATA_W'($urandom);
        data1 = (src1.size() > 0) ? src1[0] : DATA_W'($urandom);
    endtask

    task automatic clr();
        src0.delete();
        src1.delete();
        wlog_d.delete();
        wlog_p.delete();
        exp_q.delete();
        exp_p.delete();
        abort_cnt = 0;
    endtask

    task automatic wait_writes(input int n, input string name);
        int i;
        i = 0;
        while (wlog_d.size() < n && i < 40) begin
            cyc();
            #3;
            i++;
        end
        chk({name, "_reached"}, (wlog_d.size() >= n), 1);
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, wlog_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog_d.size(); i++) begin
            chk({name, "_data"}, wlog_d[i], exp_q[i]);
            chk({name, "_src"}, wlog_p[i], exp_p[i]);
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
        data0 = '0; data1 = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
        cyc();
        cyc();

        // Single burst from producer 0
        rst = 1'b0; req0 = 1'b1; len0 = 4'd3;
        clr();
        src0 = '{8'hA1, 8'hA2, 8'hA3};
        #3;
        chk("reset_gnt0", gnt0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_enb", wr_enb, 0);
        chk("reset_wr_data", wr_data, 0);
        cyc();
        req0 = 1'b0;
        #3;
        chk("t1_gnt0_rise", gnt0, 1);
        chk("t1_first_data", wr_data, 8'hA1);
        wait_writes(3, "t1");
        cyc(); cyc(); cyc();
        #3;
        chk("t1_gnt0_end", gnt0, 0);
        chk("t1_busy_end", busy, 0);
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        exp_p = '{0, 0, 0};
        check_log("t1");

        // Round-robin with both producers always requesting
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd1;
        clr();
        src0 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        src1 = '{8'hC0, 8'hC1};
        wait_writes(6, "t2");
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();
        #3;
        exp_q = '{8'hB0, 8'hB1, 8'hC0, 8'hB2, 8'hB3, 8'hC1};
        exp_p = '{0, 0, 1, 0, 0, 1};
        check_log("t2");

        // Full stall of three cycles inside a producer 1 burst
        clr();
        cyc();
        req1 = 1'b1; len1 = 4'd4;
        src1 = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        cyc();
        req1 = 1'b0;
        wait_writes(2, "t3a");
        repeat (3) begin
            cyc();
            fifo_full = 1'b1;
            #3;
            chk("t3_stall_wr_enb", wr_enb, 0);
            chk("t3_stall_ack1", ack1, 0);
            chk("t3_stall_gnt1", gnt1, 1);
        end
        cyc();
        fifo_full = 1'b0;
        wait_writes(4, "t3b");
        cyc(); cyc();
        #3;
        exp_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        exp_p = '{1, 1, 1, 1};
        check_log("t3");
        chk("t3_no_abort", abort_cnt, 0);

        // Stall abort, then producer 1 takes the next grant
        clr();
        cyc();
        req0 = 1'b1; len0 = 4'd5; req1 = 1'b1; len1 = 4'd1;
        src0 = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
        src1 = '{8'hF1};
        cyc();
        req0 = 1'b0;
        #3;
        chk("t4_gnt0", gnt0, 1);
        repeat (4) begin
            cyc();
            fifo_full = 1'b1;
        end
        cyc();
        #3;
        chk("t4_gnt0_drop", gnt0, 0);
        chk("t4_abort_pulse", stall_abort, 1);
        chk("t4_busy", busy, 0);
        cyc();
        fifo_full = 1'b0;
        #3;
        chk("t4_abort_single", stall_abort, 0);
        cyc();
        req1 = 1'b0;
        #3;
        chk("t4_gnt1_next", gnt1, 1);
        cyc(); cyc();
        #3;
        exp_q = '{8'hE1, 8'hF1};
        exp_p = '{0, 1};
        check_log("t4");
        chk("t4_abort_count", abort_cnt, 1);

        // Almost-full gate, then a zero-length request writes one beat
        clr();
        cyc();
        fifo_almost_full = 1'b1; req0 = 1'b1; len0 = 4'd0;
        src0 = '{8'h51};
        repeat (3) begin
            cyc();
            #3;
            chk("t5_af_no_gnt", gnt0, 0);
        end
        cyc();
        fifo_almost_full = 1'b0;
        cyc();
        req0 = 1'b0;
        #3;
        chk("t5_gnt0", gnt0, 1);
        cyc(); cyc(); cyc();
        #3;
        exp_q = '{8'h51};
        exp_p = '{0};
        check_log("t5");

        // Reset in the middle of a producer 1 burst
        clr();
        cyc();
        req1 = 1'b1; len1 = 4'd6;
        src1 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        cyc();
        req1 = 1'b0;
        wait_writes(2, "t6");
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 4'd1;
        #3;
        chk("t6_gnt1_cleared", gnt1, 0);
        chk("t6_wr_enb_cleared", wr_enb, 0);
        chk("t6_busy_cleared", busy, 0);
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        #3;
        chk("t6_p0_first", gnt0, 1);
        chk("t6_p1_waits", gnt1, 0);
        cyc(); cyc();

        // Randomized traffic
        clr();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst              = ($urandom_range(0, 199) == 0);
            req0             = 1'($urandom_range(0, 1));
            req1             = 1'($urandom_range(0, 1));
            len0             = LEN_W'($urandom);
            len1             = LEN_W'($urandom);
            fifo_almost_full = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) fifo_full = ~fifo_full;
        end
        cyc();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
        repeat (20) cyc();
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
